// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with a single-entry instruction
// holding register and branch redirect handling.
// FETCH requests the word at pc. HOLD presents it to decode until it is
// accepted. DRAIN waits out a request that a taken branch made stale.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN. When it is defined, a
// taken branch to a target that is not word aligned sets the sticky
// misaligned flag and is otherwise ignored for that cycle.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        branch,
  input  logic        aluZero,
  input  logic [31:0] branchBase,
  input  logic [31:0] branchOffset,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemReady,
  input  logic [31:0] imemRdata,
  output logic [31:0] instr,
  output logic [31:0] instrPc,
  output logic [31:0] add4,
  output logic        instrValid,
  input  logic        instrReady,
  output logic        misaligned
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } stateT;

  stateT       state;
  stateT       stateNext;
  logic [31:0] pc;
  logic [31:0] pcNext;
  logic [31:0] latchedTarget;
  logic [31:0] latchedNext;
  logic [31:0] instrNext;
  logic [31:0] instrPcNext;
  logic        instrValidNext;

  logic        taken;
  logic [31:0] rawTarget;
  logic [31:0] target;
  logic        misalignHit;
  logic        redirect;

  assign taken     = branch & aluZero;
  assign rawTarget = branchBase + (branchOffset << 1);

`ifdef FETCH_MISALIGN_CHECK_EN
  assign target      = rawTarget;
  assign misalignHit = taken & (rawTarget[1:0] != 2'b00);
`else
  assign target      = rawTarget & 32'hFFFF_FFFC;
  assign misalignHit = 1'b0;
`endif

  assign redirect = taken & ~misalignHit;

  // The request address always comes from pc. pc does not move while a
  // request is outstanding, so the address stays stable.
  assign imemAddr = pc;
  assign add4     = instrPc + 32'd4;

  // Next-state logic. A misaligned taken branch freezes every transition
  // for that cycle.
  always_comb begin
    stateNext      = state;
    pcNext         = pc;
    latchedNext    = latchedTarget;
    instrNext      = instr;
    instrPcNext    = instrPc;
    instrValidNext = instrValid;
    imemReq        = (state == FETCH) || (state == DRAIN);
    if (!misalignHit) begin
      case (state)
        FETCH: begin
          if (redirect) begin
            if (imemReady) begin
              pcNext = target;
            end else begin
              latchedNext = target;
              stateNext   = DRAIN;
            end
          end else if (imemReady) begin
            instrNext      = imemRdata;
            instrPcNext    = pc;
            instrValidNext = 1'b1;
            pcNext         = pc + 32'd4;
            stateNext      = HOLD;
          end
        end
        HOLD: begin
          if (redirect) begin
            instrValidNext = 1'b0;
            pcNext         = target;
            stateNext      = FETCH;
          end else if (instrReady) begin
            instrValidNext = 1'b0;
            stateNext      = FETCH;
          end
        end
        DRAIN: begin
          if (imemReady) begin
            pcNext    = redirect ? target : latchedTarget;
            stateNext = FETCH;
          end else if (redirect) begin
            latchedNext = target;
          end
        end
        default: begin
          stateNext = FETCH;
        end
      endcase
    end
  end

  // State and datapath registers. Reset overrides any in-flight request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= FETCH;
      pc            <= RESET_PC;
      latchedTarget <= 32'h0;
      instr         <= 32'h0;
      instrPc       <= 32'h0;
      instrValid    <= 1'b0;
    end else begin
      state         <= stateNext;
      pc            <= pcNext;
      latchedTarget <= latchedNext;
      instr         <= instrNext;
      instrPc       <= instrPcNext;
      instrValid    <= instrValidNext;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalignedReg;

  // Sticky misaligned-target flag. Only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      misalignedReg <= 1'b0;
    end else if (misalignHit) begin
      misalignedReg <= 1'b1;
    end
  end

  assign misaligned = misalignedReg;
`else
  assign misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
// Inputs change 1ns after the rising edge. Outputs are checked in the
// same window, before the next edge.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        branch;
  logic        aluZero;
  logic [31:0] branchBase;
  logic [31:0] branchOffset;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemReady;
  logic [31:0] imemRdata;
  logic [31:0] instr;
  logic [31:0] instrPc;
  logic [31:0] add4;
  logic        instrValid;
  logic        instrReady;
  logic        misaligned;

  int testsRun;
  int testsFailed;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk),
    .reset(reset),
    .branch(branch),
    .aluZero(aluZero),
    .branchBase(branchBase),
    .branchOffset(branchOffset),
    .imemReq(imemReq),
    .imemAddr(imemAddr),
    .imemReady(imemReady),
    .imemRdata(imemRdata),
    .instr(instr),
    .instrPc(instrPc),
    .add4(add4),
    .instrValid(instrValid),
    .instrReady(instrReady),
    .misaligned(misaligned)
  );

  // Free-running clock with a 10ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetchOne(input logic [31:0] addr);
    imemReady = 1'b0;
    tick();
    imemReady = 1'b1;
    imemRdata = memWord(addr);
    tick();
    imemReady = 1'b0;
    imemRdata = 32'h0;
  endtask

  task automatic acceptInstr();
    instrReady = 1'b1;
    tick();
    instrReady = 1'b0;
  endtask

  task automatic setBranch(input logic [31:0] base, input logic [31:0] off);
    branch       = 1'b1;
    aluZero      = 1'b1;
    branchBase   = base;
    branchOffset = off;
  endtask

  task automatic clearBranch();
    branch       = 1'b0;
    aluZero      = 1'b0;
    branchBase   = 32'h0;
    branchOffset = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    imemReady = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    imemReady = 1'b0;
    testsRun++;
    if (imemReq !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_imemReq got %b want 1", imemReq); end
    testsRun++;
    if (imemAddr !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_imemAddr got %h want 00000000", imemAddr); end
    testsRun++;
    if (instrValid !== 1'b0 || instr !== 32'h0 || instrPc !== 32'h0) begin
      testsFailed++; $display("[TB] FAIL reset_outputs got valid=%b instr=%h pc=%h want 0/0/0", instrValid, instr, instrPc);
    end
    testsRun++;
    if (misaligned !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_misaligned got %b want 0", misaligned); end
  endtask

  task automatic test_sequential();
    logic [31:0] a;
    for (int k = 0; k < 3; k++) begin
      a = 32'(k * 4);
      testsRun++;
      if (imemReq !== 1'b1 || imemAddr !== a) begin
        testsFailed++; $display("[TB] FAIL seq_req got req=%b addr=%h want 1/%h", imemReq, imemAddr, a);
      end
      fetchOne(a);
      testsRun++;
      if (instrValid !== 1'b1 || instrPc !== a || add4 !== a + 32'd4) begin
        testsFailed++; $display("[TB] FAIL seq_present got v=%b pc=%h add4=%h want 1/%h/%h", instrValid, instrPc, add4, a, a + 32'd4);
      end
      testsRun++;
      if (instr !== memWord(a) || imemReq !== 1'b0) begin
        testsFailed++; $display("[TB] FAIL seq_instr got instr=%h req=%b want %h/0", instr, imemReq, memWord(a));
      end
      acceptInstr();
      testsRun++;
      if (instrValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL seq_accept got valid=%b want 0", instrValid); end
    end
  endtask

  task automatic test_hold();
    fetchOne(32'h0C);
    for (int i = 0; i < 3; i++) begin
      tick();
      testsRun++;
      if (instrValid !== 1'b1 || instrPc !== 32'h0C || instr !== memWord(32'h0C) || imemReq !== 1'b0) begin
        testsFailed++; $display("[TB] FAIL hold_stable cycle %0d got v=%b pc=%h instr=%h req=%b want 1/0000000c/%h/0",
                                i, instrValid, instrPc, instr, imemReq, memWord(32'h0C));
      end
    end
    acceptInstr();
    testsRun++;
    if (imemReq !== 1'b1 || imemAddr !== 32'h10) begin
      testsFailed++; $display("[TB] FAIL hold_release got req=%b addr=%h want 1/00000010", imemReq, imemAddr);
    end
  endtask

  task automatic test_branch_hold();
    fetchOne(32'h10);
    setBranch(32'h10, 32'h8);
    aluZero = 1'b0;
    tick();
    testsRun++;
    if (instrValid !== 1'b1 || instrPc !== 32'h10) begin
      testsFailed++; $display("[TB] FAIL branch_not_taken got v=%b pc=%h want 1/00000010", instrValid, instrPc);
    end
    aluZero = 1'b1;
    tick();
    clearBranch();
    testsRun++;
    if (instrValid !== 1'b0 || imemReq !== 1'b1 || imemAddr !== 32'h20) begin
      testsFailed++; $display("[TB] FAIL branch_hold got v=%b req=%b addr=%h want 0/1/00000020", instrValid, imemReq, imemAddr);
    end
  endtask

  task automatic test_branch_fetch();
    setBranch(32'h40, 32'hFFFF_FFFC);
    imemReady = 1'b0;
    tick();
    clearBranch();
    testsRun++;
    if (imemReq !== 1'b1 || imemAddr !== 32'h20) begin
      testsFailed++; $display("[TB] FAIL drain_enter got req=%b addr=%h want 1/00000020", imemReq, imemAddr);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      testsRun++;
      if (imemAddr !== 32'h20 || instrValid !== 1'b0) begin
        testsFailed++; $display("[TB] FAIL drain_wait got addr=%h v=%b want 00000020/0", imemAddr, instrValid);
      end
    end
    imemReady = 1'b1;
    imemRdata = 32'hDEAD_BEEF;
    tick();
    imemReady = 1'b0;
    testsRun++;
    if (instrValid !== 1'b0 || imemReq !== 1'b1 || imemAddr !== 32'h38) begin
      testsFailed++; $display("[TB] FAIL drain_exit got v=%b req=%b addr=%h want 0/1/00000038", instrValid, imemReq, imemAddr);
    end
    fetchOne(32'h38);
    testsRun++;
    if (instrValid !== 1'b1 || instrPc !== 32'h38 || instr !== memWord(32'h38)) begin
      testsFailed++; $display("[TB] FAIL drain_refetch got v=%b pc=%h instr=%h want 1/00000038/%h", instrValid, instrPc, instr, memWord(32'h38));
    end
    acceptInstr();
  endtask

  task automatic test_taken_with_ready();
    setBranch(32'h100, 32'h10);
    imemReady = 1'b1;
    imemRdata = 32'hBAD0_BAD0;
    tick();
    imemReady = 1'b0;
    clearBranch();
    testsRun++;
    if (instrValid !== 1'b0 || imemReq !== 1'b1 || imemAddr !== 32'h120) begin
      testsFailed++; $display("[TB] FAIL taken_ready got v=%b req=%b addr=%h want 0/1/00000120", instrValid, imemReq, imemAddr);
    end
  endtask

  task automatic test_drain_overwrite();
    setBranch(32'h200, 32'h0);
    tick();
    setBranch(32'h300, 32'h2);
    tick();
    clearBranch();
    testsRun++;
    if (imemAddr !== 32'h120 || imemReq !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL overwrite_hold got addr=%h req=%b want 00000120/1", imemAddr, imemReq);
    end
    imemReady = 1'b1;
    tick();
    imemReady = 1'b0;
    testsRun++;
    if (imemAddr !== 32'h304 || instrValid !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL overwrite_target got addr=%h v=%b want 00000304/0", imemAddr, instrValid);
    end
  endtask

  task automatic test_misalign();
    setBranch(32'h10, 32'h1);
    imemReady = 1'b1;
    imemRdata = 32'h5555_AAAA;
    tick();
    imemReady = 1'b0;
    clearBranch();
`ifdef FETCH_MISALIGN_CHECK_EN
    testsRun++;
    if (misaligned !== 1'b1 || imemAddr !== 32'h304 || instrValid !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL misalign_on got m=%b addr=%h v=%b want 1/00000304/0", misaligned, imemAddr, instrValid);
    end
`else
    testsRun++;
    if (misaligned !== 1'b0 || imemAddr !== 32'h10 || instrValid !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL misalign_off got m=%b addr=%h v=%b want 0/00000010/0", misaligned, imemAddr, instrValid);
    end
`endif
  endtask

  task automatic test_wrap();
    setBranch(32'hFFFF_FFF0, 32'h6);
    imemReady = 1'b1;
    tick();
    imemReady = 1'b0;
    clearBranch();
    testsRun++;
    if (imemAddr !== 32'hFFFF_FFFC) begin testsFailed++; $display("[TB] FAIL wrap_target got %h want fffffffc", imemAddr); end
    fetchOne(32'hFFFF_FFFC);
    testsRun++;
    if (instrPc !== 32'hFFFF_FFFC || add4 !== 32'h0) begin
      testsFailed++; $display("[TB] FAIL wrap_add4 got pc=%h add4=%h want fffffffc/00000000", instrPc, add4);
    end
    acceptInstr();
    testsRun++;
    if (imemAddr !== 32'h0 || imemReq !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL wrap_pc got addr=%h req=%b want 00000000/1", imemAddr, imemReq);
    end
  endtask

  task automatic test_reset_in_drain();
    fetchOne(32'h0);
    acceptInstr();
    setBranch(32'h80, 32'h0);
    tick();
    clearBranch();
    testsRun++;
    if (imemAddr !== 32'h4 || imemReq !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL rstdrain_pre got addr=%h req=%b want 00000004/1", imemAddr, imemReq);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    testsRun++;
    if (imemAddr !== 32'h0 || imemReq !== 1'b1 || instrValid !== 1'b0 || misaligned !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL rstdrain_post got addr=%h req=%b v=%b m=%b want 00000000/1/0/0", imemAddr, imemReq, instrValid, misaligned);
    end
    imemReady = 1'b1;
    imemRdata = memWord(32'h0);
    tick();
    imemReady = 1'b0;
    testsRun++;
    if (instrValid !== 1'b1 || instrPc !== 32'h0 || instr !== memWord(32'h0)) begin
      testsFailed++; $display("[TB] FAIL rstdrain_late got v=%b pc=%h instr=%h want 1/00000000/%h", instrValid, instrPc, instr, memWord(32'h0));
    end
  endtask

  // Scenario sequence. Each scenario starts from the state the previous one left.
  initial begin
    testsRun     = 0;
    testsFailed  = 0;
    reset        = 1'b1;
    branch       = 1'b0;
    aluZero      = 1'b0;
    branchBase   = 32'h0;
    branchOffset = 32'h0;
    imemReady    = 1'b0;
    imemRdata    = 32'h0;
    instrReady   = 1'b0;
    test_reset();
    test_sequential();
    test_hold();
    test_branch_hold();
    test_branch_fetch();
    test_taken_with_ready();
    test_drain_overwrite();
    test_misalign();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    test_wrap();
    test_reset_in_drain();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 branch  input  1  decoded instruction is a conditional branch.
REQ-005 aluZero  input  1  ALU zero flag for that branch.
REQ-006 branchBase  input  32  PC of the branch instruction.
REQ-007 branchOffset  input  32  sign-extended immediate, halfword units.
REQ-008 imemReq  output  1  fetch request; held high until imemReady.
REQ-009 imemAddr  output  32  fetch address; stable while imemReq high.
REQ-010 imemReady  input  1  memory response valid this cycle.
REQ-011 imemRdata  input  32  fetched instruction word.
REQ-012 instr  output  32  instruction presented to decode.
REQ-013 instrPc  output  32  address of instr.
REQ-014 add4  output  32  instrPc + 4.
REQ-015 instrValid  output  1  instr/instrPc/add4 valid.
REQ-016 instrReady  input  1  decode accepts instr this cycle.
REQ-017 misaligned  output  1  sticky misaligned-target flag (see Configuration).

Function
REQ-018 Internal taken = branch & aluZero; target = branchBase + (branchOffset << 1), modulo 2^32.
REQ-019 States: FETCH, HOLD, DRAIN.
REQ-020 FETCH: imemReq=1, imemAddr=pc; on imemReady without taken: instr<=imemRdata, instrPc<=pc, instrValid<=1, pc<=pc+4, go HOLD.
REQ-021 HOLD: imemReq=0; instr, instrPc, add4 held stable while instrValid=1 and instrReady=0.
REQ-022 HOLD with instrReady=1 and no taken: instrValid<=0, go FETCH.
REQ-023 Taken in HOLD (any instrReady): instrValid<=0, pc<=target, go FETCH; held instruction discarded.
REQ-024 Taken in FETCH with imemReady same cycle: response discarded, pc<=target, stay FETCH.
REQ-025 Taken in FETCH without imemReady: latch target, go DRAIN; imemAddr unchanged.
REQ-026 DRAIN: imemReq=1, imemAddr held; later taken overwrites latched target; on imemReady: response discarded, pc<=latched target (or same-cycle target if taken), go FETCH.
REQ-027 instrValid never asserted for a discarded response.
REQ-028 pc+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000; no flag.
REQ-029 add4 is combinational from instrPc.

Reset
REQ-030 reset has priority over all inputs, including mid-request and mid-DRAIN.
REQ-031 Next cycle after reset: state FETCH, pc=RESET_PC, imemReq=1, imemAddr=RESET_PC, instrValid=0, instr=0, instrPc=0, misaligned=0; a response pending across reset is not tracked.

Configuration
REQ-032 Macro FETCH_MISALIGN_CHECK_EN.
REQ-033 Defined: taken with target[1:0]!=0 sets misaligned (sticky until reset), suppresses redirect and state change for that cycle.
REQ-034 Undefined: target[1:0] forced to 2'b00; misaligned tied 0.

Verification
REQ-035 Reset, RESET_PC=0, imemReady 1 cycle after req, instrReady=1 -> instrPc 0,4,8 in order, add4 4,8,12.
REQ-036 instrReady low 3 cycles in HOLD -> instr/instrPc stable, imemReq=0 throughout.
REQ-037 Taken in HOLD, branchBase=0x10, offset=8 -> held instr dropped, next imemAddr=0x20.
REQ-038 Taken in FETCH, imemReady 3 cycles later, base=0x40, offset=-4 -> imemAddr held, response dropped, next imemAddr=0x38, instrValid stays 0.
REQ-039 Macro defined, base=0x10, offset=1 -> misaligned=1, pc unchanged; undefined -> next imemAddr=0x10.
REQ-040 reset asserted in DRAIN -> next cycle imemAddr=RESET_PC, instrValid=0, late imemReady treated as response to RESET_PC.
